k10_sim_console: RTL and testbench

K10_SIM_CONSOLE -- requirements
Module: k10_sim_console

---
 rtl/k10_sim_console.sv | 122 ++++++++++++
 tb/tb_k10_sim_console.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/k10_sim_console.sv
// k10_sim_console: queues console bytes and an end-of-test code, forwarding each
// as a single AXI4-Lite write to the simulation-controller register block.
module k10_sim_console #(
  parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
  parameter int          DEPTH     = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_char_valid,
  input  logic [7:0]  i_char_data,
  output logic        o_char_ready,
  input  logic        i_end_valid,
  input  logic        i_end_pass,
  output logic        o_busy,
  output logic        o_halted,
  output logic        o_err,
  output logic [15:0] o_tx_count,
  output logic [31:0] m_axi_awaddr,
  output logic [2:0]  m_axi_awprot,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, SEND, RESP, HALT} state_t;
  state_t        state_q, state_d;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          end_pending_q, end_pending_d, end_pass_q, end_pass_d;
  logic          awvalid_q, awvalid_d, wvalid_q, wvalid_d, kind_q, kind_d;
  logic [31:0]   awaddr_q, awaddr_d, wdata_q, wdata_d;
  logic          err_q, err_d;
  logic [15:0]   tx_count_q, tx_count_d;
  logic          empty, full, push, pop, start, aw_done, w_done, b_done, end_accept;
  assign empty   = cnt_q == '0;
  assign full    = cnt_q == (AW+1)'(DEPTH);
  assign push    = i_char_valid && o_char_ready;
  assign pop     = state_q == IDLE && !empty;
  assign start   = state_q == IDLE && (!empty || end_pending_q);
  assign aw_done = !awvalid_q || m_axi_awready;
  assign w_done  = !wvalid_q || m_axi_wready;
  assign b_done  = state_q == RESP && m_axi_bvalid;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = 4'b1111;
  assign m_axi_wvalid  = wvalid_q;
  assign o_err         = err_q;
  assign o_tx_count    = tx_count_q;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? SEND : IDLE;
      SEND:    state_d = (aw_done && w_done) ? RESP : SEND;
      RESP:    state_d = !m_axi_bvalid ? RESP : kind_q ? HALT : IDLE;
      default: state_d = HALT;
    endcase
  end
  always_comb begin
    o_halted     = state_q == HALT;
    o_char_ready = !full && !end_pending_q && state_q != HALT;
    o_busy       = !empty || state_q == SEND || state_q == RESP || end_pending_q;
    m_axi_bready = state_q == RESP;
  end
  // kind_q = 1 marks the END write; it is only chosen once the FIFO is empty
  always_comb begin
    wptr_d        = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d        = pop ? rptr_q + AW'(1) : rptr_q;
    cnt_d         = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    awvalid_d     = start || (awvalid_q && !m_axi_awready);
    wvalid_d      = start || (wvalid_q && !m_axi_wready);
    kind_d        = start ? empty : kind_q;
    awaddr_d      = start ? (empty ? BASE_ADDR : BASE_ADDR + 32'd4) : awaddr_q;
    wdata_d       = start ? (empty ? {31'd0, end_pass_q} : {24'd0, mem_q[rptr_q]}) : wdata_q;
    end_accept    = i_end_valid && !end_pending_q && state_q != HALT;
    end_pending_d = end_accept || (end_pending_q && !(b_done && kind_q));
    end_pass_d    = end_accept ? i_end_pass : end_pass_q;
    err_d         = err_q || (b_done && m_axi_bresp != 2'b00);
    tx_count_d    = tx_count_q + 16'(b_done && !kind_q);
  end
  always_ff @(posedge i_clk)
    if (push) mem_q[wptr_q] <= i_char_data;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      wptr_q        <= '0;
      rptr_q        <= '0;
      cnt_q         <= '0;
      end_pending_q <= 1'b0;
      end_pass_q    <= 1'b0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      kind_q        <= 1'b0;
      awaddr_q      <= '0;
      wdata_q       <= '0;
      err_q         <= 1'b0;
      tx_count_q    <= '0;
    end else begin
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      cnt_q         <= cnt_d;
      end_pending_q <= end_pending_d;
      end_pass_q    <= end_pass_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      kind_q        <= kind_d;
      awaddr_q      <= awaddr_d;
      wdata_q       <= wdata_d;
      err_q         <= err_d;
      tx_count_q    <= tx_count_d;
    end
endmodule

// File: tb/tb_k10_sim_console.sv
// tb_k10_sim_console: directed and randomized checks of the console writer against
// a queue-based model of the AXI writes it must produce.
module tb_k10_sim_console;
  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'h2000_0000;
  logic        i_clk = 1'b0, i_rst_n = 1'b0;
  logic        i_char_valid = 1'b0, i_end_valid = 1'b0, i_end_pass = 1'b0;
  logic [7:0]  i_char_data = '0;
  logic        o_char_ready, o_busy, o_halted, o_err;
  logic [15:0] o_tx_count;
  logic [31:0] m_axi_awaddr, m_axi_wdata;
  logic [2:0]  m_axi_awprot;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready;
  logic        m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_bvalid = 1'b0;
  logic [1:0]  m_axi_bresp = 2'b00;
  always #5 i_clk = ~i_clk;
  k10_sim_console #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_char_valid(i_char_valid), .i_char_data(i_char_data),
    .o_char_ready(o_char_ready), .i_end_valid(i_end_valid), .i_end_pass(i_end_pass),
    .o_busy(o_busy), .o_halted(o_halted), .o_err(o_err), .o_tx_count(o_tx_count),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );
  int          checks = 0, errors = 0;
  logic [63:0] exp_q[$], cap_q[$];
  int          exp_tx = 0;
  bit          exp_err = 0, exp_end = 0, end_seen = 0, end_pass_m = 0;
  int          aw_delay = 0, w_delay = 0, b_delay = 0;
  bit          aw_hold = 0, rnd_slave = 0, err_next = 0;
  bit          got_aw, got_w, bready_prev;
  int          aw_cnt, w_cnt, b_cnt;
  logic [31:0] cap_addr, cap_data;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  // Offer one byte (and optionally an end request) for exactly one clock edge.
  task automatic offer(input logic [7:0] b, input bit ev, input bit ep, output bit ok);
    i_char_valid = 1'b1;
    i_char_data  = b;
    i_end_valid  = ev;
    i_end_pass   = ep;
    ok = o_char_ready;
    if (ok) begin
      exp_q.push_back({BASE + 32'd4, 24'd0, b});
      exp_tx++;
    end
    if (ev && !end_seen) begin
      end_seen   = 1;
      exp_end    = 1;
      end_pass_m = ep;
    end
    @(posedge i_clk);
    #1;
    i_char_valid = 1'b0;
    i_end_valid  = 1'b0;
    @(negedge i_clk);
  endtask
  task automatic wait_idle(input string tag);
    int n = 0;
    while (o_busy && n < 400) begin
      @(negedge i_clk);
      n++;
    end
    chk(tag, 64'(o_busy), 64'd0);
  endtask
  task automatic compare(input string tag);
    if (exp_end) exp_q.push_back({BASE, 31'd0, end_pass_m});
    exp_end = 0;
    chk({tag, " count"}, 64'(cap_q.size()), 64'(exp_q.size()));
    foreach (exp_q[i]) chk({tag, " write"}, (cap_q.size() > i) ? cap_q[i] : ~exp_q[i], exp_q[i]);
    exp_q.delete();
    cap_q.delete();
    chk({tag, " tx_count"}, 64'(o_tx_count), 64'(exp_tx[15:0]));
    chk({tag, " err"}, 64'(o_err), 64'(exp_err));
  endtask
  task automatic clear_model();
    exp_q.delete();
    cap_q.delete();
    exp_tx = 0;
    exp_err = 0;
    exp_end = 0;
    end_seen = 0;
  endtask
  // AXI slave: readies decided on the falling edge take effect at the next rising edge.
  initial forever begin
    @(negedge i_clk);
    if (!i_rst_n) begin
      m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
      got_aw = 0; got_w = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0; bready_prev = 0;
    end else begin
      m_axi_awready = 0;
      m_axi_wready  = 0;
      if (m_axi_bvalid && bready_prev) begin
        m_axi_bvalid = 0;
        got_aw = 0; got_w = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        if (rnd_slave) begin
          aw_delay = $urandom_range(0, 3);
          w_delay  = $urandom_range(0, 3);
          b_delay  = $urandom_range(0, 2);
        end
      end else if (got_aw && got_w && !m_axi_bvalid) begin
        if (b_cnt >= b_delay) begin
          m_axi_bvalid = 1;
          m_axi_bresp  = err_next ? 2'b10 : 2'b00;
          if (err_next) exp_err = 1;
          err_next = rnd_slave ? ($urandom_range(0, 7) == 0) : 1'b0;
          cap_q.push_back({cap_addr, cap_data});
        end else b_cnt++;
      end
      if (m_axi_awvalid && !got_aw && !aw_hold) begin
        if (aw_cnt >= aw_delay) begin
          m_axi_awready = 1; got_aw = 1; cap_addr = m_axi_awaddr;
        end else aw_cnt++;
      end
      if (m_axi_wvalid && !got_w) begin
        if (w_cnt >= w_delay) begin
          m_axi_wready = 1; got_w = 1; cap_data = m_axi_wdata;
        end else w_cnt++;
      end
      bready_prev = m_axi_bready;
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    bit          ok;
    int          acc, n, held;
    logic [31:0] addr0;
    repeat (3) @(negedge i_clk);
    i_rst_n = 1;
    @(negedge i_clk);
    chk("rst ready", 64'(o_char_ready), 64'd1);
    chk("rst busy", 64'(o_busy), 64'd0);
    chk("rst halted", 64'(o_halted), 64'd0);
    chk("rst err", 64'(o_err), 64'd0);
    chk("rst tx_count", 64'(o_tx_count), 64'd0);
    chk("rst awvalid", 64'(m_axi_awvalid), 64'd0);
    chk("rst wvalid", 64'(m_axi_wvalid), 64'd0);
    chk("rst bready", 64'(m_axi_bready), 64'd0);
    chk("rst awaddr", 64'(m_axi_awaddr), 64'd0);
    chk("rst wdata", 64'(m_axi_wdata), 64'd0);
    chk("awprot", 64'(m_axi_awprot), 64'd0);
    chk("wstrb", 64'(m_axi_wstrb), 64'hf);
    offer(8'h48, 0, 0, ok);
    chk("push H", 64'(ok), 64'd1);
    chk("latency 1st edge", 64'(m_axi_awvalid), 64'd0);
    offer(8'h69, 0, 0, ok);
    chk("push i", 64'(ok), 64'd1);
    chk("latency 2nd edge", 64'(m_axi_awvalid), 64'd1);
    wait_idle("hi idle");
    compare("hi");
    aw_hold = 1;
    acc = 0;
    for (int i = 0; i <= DEPTH; i++) begin
      offer(8'($urandom), 0, 0, ok);
      acc += int'(ok);
    end
    chk("fill accepted", 64'(acc), 64'(DEPTH + 1));
    chk("fill ready low", 64'(o_char_ready), 64'd0);
    offer(8'hAA, 0, 0, ok);
    chk("fill refused", 64'(ok), 64'd0);
    aw_hold = 0;
    wait_idle("fill idle");
    compare("fill");
    aw_delay = 3;
    offer(8'h5A, 0, 0, ok);
    n = 0;
    while (!m_axi_awvalid && n < 10) begin
      @(negedge i_clk);
      n++;
    end
    chk("slow aw seen", 64'(m_axi_awvalid), 64'd1);
    addr0 = m_axi_awaddr;
    held = 0;
    while (m_axi_awvalid && held < 20) begin
      chk("slow aw addr stable", 64'(m_axi_awaddr), 64'(addr0));
      if (held == 1) chk("slow w dropped", 64'(m_axi_wvalid), 64'd0);
      held++;
      @(negedge i_clk);
    end
    chk("slow aw held", 64'(held), 64'd4);
    aw_delay = 0;
    wait_idle("slow idle");
    compare("slow aw");
    err_next = 1;
    offer(8'h31, 0, 0, ok);
    offer(8'h32, 0, 0, ok);
    wait_idle("bresp idle");
    compare("bresp err");
    rnd_slave = 1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge i_clk);
      offer(8'($urandom), 0, 0, ok);
    end
    wait_idle("random idle");
    rnd_slave = 0;
    err_next = 0;
    aw_delay = 0; w_delay = 0; b_delay = 0;
    compare("random");
    aw_hold = 1;
    offer(8'h77, 0, 0, ok);
    n = 0;
    while (!m_axi_awvalid && n < 10) begin
      @(negedge i_clk);
      n++;
    end
    chk("abort in send", 64'(m_axi_awvalid), 64'd1);
    #2 i_rst_n = 0;
    #1;
    chk("abort awvalid", 64'(m_axi_awvalid), 64'd0);
    chk("abort wvalid", 64'(m_axi_wvalid), 64'd0);
    chk("abort bready", 64'(m_axi_bready), 64'd0);
    chk("abort busy", 64'(o_busy), 64'd0);
    chk("abort err", 64'(o_err), 64'd0);
    chk("abort tx_count", 64'(o_tx_count), 64'd0);
    chk("abort awaddr", 64'(m_axi_awaddr), 64'd0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1;
    aw_hold = 0;
    clear_model();
    @(negedge i_clk);
    chk("post rst ready", 64'(o_char_ready), 64'd1);
    offer(8'h21, 0, 0, ok);
    wait_idle("post rst idle");
    compare("post rst");
    offer(8'h41, 0, 0, ok);
    offer(8'h42, 1, 1, ok);
    offer(8'h43, 0, 0, ok);
    chk("push after end refused", 64'(ok), 64'd0);
    wait_idle("end idle");
    compare("end");
    chk("end halted", 64'(o_halted), 64'd1);
    chk("end ready", 64'(o_char_ready), 64'd0);
    offer(8'h44, 1, 0, ok);
    chk("halt push refused", 64'(ok), 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk("halt no awvalid", 64'(m_axi_awvalid), 64'd0);
      @(negedge i_clk);
    end
    chk("halt still halted", 64'(o_halted), 64'd1);
    chk("halt no writes", 64'(cap_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
